// File: rtl/arb_pkg.sv
// Shared constants and state type for the round-robin arbiter.
// Configuration macro: ARB_TIMEOUT_EN (enables hold-timeout preemption).
package arb_pkg;

   localparam int unsigned N_REQ    = 8;   // requesters, fixed to mux width
   localparam int unsigned SEL_W    = 3;   // log2(N_REQ)
   localparam int unsigned MAX_HOLD = 16;  // default grant length limit

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/arb_rr_8_rr_pick.sv
// rr_pick: combinational rotating priority encoder.
// Scans req starting at ptr, ptr+1, ... wrapping, and reports the first set bit.
// Ports:
//   req  in  N_REQ  request vector
//   ptr  in  SEL_W  index with highest priority
//   hit  out 1      at least one request present
//   idx  out SEL_W  index of selected requester (0 when no hit)
module rr_pick
   import arb_pkg::*;
#(
   parameter int unsigned NUM = N_REQ,
   parameter int unsigned SW  = SEL_W
) (
   input  logic [NUM-1:0] req,
   input  logic [SW-1:0]  ptr,
   output logic           hit,
   output logic [SW-1:0]  idx
);

   logic [SW-1:0] cand;

   // NUM is a power of two, so SW-bit addition wraps 7->0 by itself.
   always_comb begin
      hit  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int unsigned i = 0; i < NUM; i++) begin
         cand = ptr + SW'(i);
         if (!hit && req[cand]) begin
            hit = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/arb_rr_8.sv
// arb_rr_8: round-robin arbiter sharing one 8:1 mux among eight requesters.
// A grant is held until the owner drops its request; the priority pointer
// then moves to the requester after the owner. One idle cycle always
// separates successive grants.
// Configuration macro: ARB_TIMEOUT_EN -- when defined, a grant held for
// MAX_HOLD cycles with the request still high is revoked and preempt pulses.
// Ports:
//   clk      in  1      system clock, rising edge
//   rst      in  1      synchronous active-high reset
//   req      in  8      request vector
//   grant    out 8      one-hot registered grant, zero when idle
//   opt      out 3      mux select = owner index, held while idle
//   valid    out 1      grant active
//   preempt  out 1      one-cycle pulse on timeout release
module arb_rr_8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD_CYC = MAX_HOLD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   output logic [N_REQ-1:0]   grant,
   output logic [SEL_W-1:0]   opt,
   output logic               valid,
   output logic               preempt
);

   if (MAX_HOLD_CYC < 1 || MAX_HOLD_CYC > 255) begin : g_bad_hold
      $error("MAX_HOLD_CYC must be in 1..255");
   end

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   ptr, ptr_nxt;
   logic [N_REQ-1:0]   grant_nxt;
   logic [SEL_W-1:0]   opt_nxt;
   logic               preempt_nxt;
   logic               pick_hit;
   logic [SEL_W-1:0]   pick_idx;
   logic               owner_req;
   logic               timeout;
   logic               release_now;

   rr_pick #(
      .NUM (N_REQ),
      .SW  (SEL_W)
   ) u_pick (
      .req (req),
      .ptr (ptr),
      .hit (pick_hit),
      .idx (pick_idx)
   );

   // opt holds the owner index for the whole grant, so it doubles as owner.
   assign owner_req = req[opt];

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_cnt;

   // Counts completed GRANT cycles; zero during the first grant cycle.
   always_ff @(posedge clk) begin
      if (rst || state == IDLE) hold_cnt <= '0;
      else                      hold_cnt <= hold_cnt + 8'd1;
   end

   assign timeout = (hold_cnt == 8'(MAX_HOLD_CYC - 1));
`else
   assign timeout = 1'b0;
`endif

   assign release_now = (state == GRANT) && (!owner_req || timeout);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (pick_hit)    state_nxt = GRANT;
         GRANT:   if (release_now) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs and pointer
   always_comb begin
      grant_nxt   = grant;
      opt_nxt     = opt;
      ptr_nxt     = ptr;
      preempt_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_hit) begin
               grant_nxt = N_REQ'(1) << pick_idx;
               opt_nxt   = pick_idx;
            end
         end
         GRANT: begin
            if (release_now) begin
               grant_nxt   = '0;
               ptr_nxt     = opt + SEL_W'(1);
               preempt_nxt = owner_req && timeout;
            end
         end
         default: grant_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant   <= '0;
         opt     <= '0;
         ptr     <= '0;
         preempt <= 1'b0;
      end else begin
         grant   <= grant_nxt;
         opt     <= opt_nxt;
         ptr     <= ptr_nxt;
         preempt <= preempt_nxt;
      end
   end

   assign valid = |grant;

endmodule

// File: tb/tb_arb_rr_8.sv
// Scoreboard testbench for arb_rr_8. The stimulus process drives req/rst on
// the falling edge, advances a behavioural model and queues the expected
// outputs; the monitor pops and compares one entry after every rising edge.
module tb_arb_rr_8;

   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic [7:0] grant;
   logic [2:0] opt;
   logic       valid;
   logic       preempt;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] grant;
      logic [2:0] opt;
      logic       valid;
      logic       preempt;
   } exp_t;

   exp_t exp_q[$];

   // Model state: owner = -1 when idle; hold = cycles the grant has been visible.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_opt   = 0;
   int m_hold  = 0;
   bit m_pre   = 0;

`ifdef ARB_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   arb_rr_8 #(.MAX_HOLD_CYC(HOLD)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .grant   (grant),
      .opt     (opt),
      .valid   (valid),
      .preempt (preempt)
   );

   always #5 clk = ~clk;

   task automatic model_step(input logic r, input logic [7:0] q);
      int k;
      if (r) begin
         m_owner = -1; m_ptr = 0; m_opt = 0; m_hold = 0; m_pre = 0;
         return;
      end
      m_pre = 0;
      if (m_owner < 0) begin
         for (int i = 0; i < 8; i++) begin
            k = (m_ptr + i) % 8;
            if (q[k] && m_owner < 0) begin
               m_owner = k; m_opt = k; m_hold = 1;
            end
         end
      end else if (!q[m_owner]) begin
         m_ptr = (m_owner + 1) % 8;
         m_owner = -1;
      end else if (TIMEOUT_ON && m_hold >= HOLD) begin
         m_ptr = (m_owner + 1) % 8;
         m_owner = -1;
         m_pre = 1;
      end else begin
         m_hold++;
      end
   endtask

   task automatic cyc(input logic r, input logic [7:0] q);
      exp_t e;
      @(negedge clk);
      rst = r;
      req = q;
      model_step(r, q);
      e.grant   = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
      e.opt     = 3'(m_opt);
      e.valid   = (m_owner >= 0);
      e.preempt = m_pre;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant",   int'(grant),   int'(e.grant));
            chk("opt",     int'(opt),     int'(e.opt));
            chk("valid",   int'(valid),   int'(e.valid));
            chk("preempt", int'(preempt), int'(e.preempt));
         end
      end
   end

   // Stimulus
   initial begin
      logic [7:0] q;
      int guard;

      // Reset held with all requests high, then release.
      repeat (3) cyc(1'b1, 8'hFF);
      repeat (3) cyc(1'b0, 8'hFF);

      // Basic: ptr=0, req 0000_0101, then drop bit 0.
      cyc(1'b1, 8'h00);
      repeat (3) cyc(1'b0, 8'h05);
      repeat (4) cyc(1'b0, 8'h04);
      repeat (2) cyc(1'b0, 8'h00);

      // Wrap: owner 6 released -> ptr=7, then 1000_0001.
      cyc(1'b1, 8'h00);
      repeat (3) cyc(1'b0, 8'h40);
      cyc(1'b0, 8'h00);
      repeat (3) cyc(1'b0, 8'h81);
      repeat (4) cyc(1'b0, 8'h01);
      repeat (2) cyc(1'b0, 8'h00);

      // Fairness: all request, owner drops after 3 cycles of grant.
      cyc(1'b1, 8'h00);
      for (int n = 0; n < 45; n++) begin
         q = 8'hFF;
         if (m_owner >= 0 && m_hold >= 3) q[m_owner] = 1'b0;
         cyc(1'b0, q);
      end
      cyc(1'b0, 8'h00);

      // Timeout / indefinite hold with two persistent requesters.
      cyc(1'b1, 8'h00);
      repeat (100) cyc(1'b0, 8'h03);
      cyc(1'b0, 8'h00);

      // Request dropped in the cycle it is granted.
      cyc(1'b0, 8'h10);
      repeat (3) cyc(1'b0, 8'h00);

      // Reset mid-grant of requester 5.
      cyc(1'b1, 8'h00);
      repeat (4) cyc(1'b0, 8'h20);
      cyc(1'b1, 8'h20);
      repeat (4) cyc(1'b0, 8'hFF);

      // Random traffic; the owner mostly keeps its request.
      for (int n = 0; n < 600; n++) begin
         q = 8'($urandom);
         if ($urandom_range(0, 7) == 0) q = 8'h00;
         if (m_owner >= 0) q[m_owner] = ($urandom_range(0, 5) != 0);
         cyc($urandom_range(0, 79) == 0, q);
      end

      // Drain the scoreboard with a bounded wait.
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arb_rr_8.md
# arb_rr_8

Round-robin arbiter sharing one 8:1 mux (`mux_8_1`) among eight requesters. Each requester raises its `req` bit; the arbiter grants exactly one, drives the mux select `opt` with the owner's index and holds the grant until that requester drops its request. Fairness comes from a rotating priority pointer; an optional hold-timeout preempts owners that keep the resource too long.

## Interface
- `N_REQ`, 8: number of requesters; fixed to mux width.
- `SEL_W`, 3: select width, log2(`N_REQ`).
- `MAX_HOLD`, 16: maximum grant length in cycles; used only with `ARB_TIMEOUT_EN`; legal range 1..255.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request vector; bit k = requester k.
- `grant`  out  8  one-hot grant, registered; all-zero when idle.
- `opt`  out  3  mux select = index of owner; drives `mux_8_1.opt`.
- `valid`  out  1  high while a grant is active (OR of `grant`).
- `preempt`  out  1  one-cycle pulse when a grant is revoked by timeout; tied 0 without `ARB_TIMEOUT_EN`.

## Operation
- Reset: `grant`=0, `opt`=0, `valid`=0, `preempt`=0, pointer `ptr`=0, state IDLE, hold counter=0.
- States: IDLE, GRANT.
- IDLE: if `req`≠0, select first set bit scanning `ptr`, `ptr`+1, …, wrapping 7→0; register grant/`opt`/`valid`; go GRANT. If `req`=0, stay.
- GRANT: hold `grant` and `opt` stable while `req[owner]`=1. Other `req` bits are ignored (no preemption by priority).
- Release: `req[owner]`=0 → clear `grant`/`valid`, `ptr` ← (owner+1) mod 8, go IDLE. `opt` keeps last value while idle.
- One idle cycle always separates successive grants; `opt` never changes while `valid`=1.
- Pointer arithmetic is 3-bit modulo; owner 7 → `ptr`=0.
- Reset has priority over every event, including mid-grant: next cycle all outputs at reset values.

## Timing
- Request to grant: `req` sampled high in IDLE at edge t → `grant`/`opt`/`valid` valid after edge t.
- Release: `req[owner]` sampled low at edge t → `valid`=0 after t; earliest next grant after t+1.
- Request dropped the same cycle it is granted: grant still issued, released the following edge.
- All outputs registered; no combinational path `req` → outputs.

## Configuration
- `ARB_TIMEOUT_EN` defined: hold counter increments each GRANT cycle; grant to owner reaches `MAX_HOLD` cycles with `req[owner]` still high → forced release exactly as a normal release (`ptr` advances, IDLE), `preempt` pulses high in the cycle `valid` falls. A sole persistent requester is regranted after the idle cycle. Counter clears on entering GRANT.
- Not defined: no counter, no preemption, `preempt`=0 constantly; grant held indefinitely.

## Structure
- Package `arb_pkg`: `N_REQ`, `SEL_W`, state enum (IDLE, GRANT), `MAX_HOLD` default.
- Sub-module `rr_pick`: combinational rotating priority encoder (`req`, `ptr` → `hit`, `idx`); FSM, pointer and counter stay in `arb_rr_8`.

## Test plan
- Reset: hold `rst`=1 with `req`=8'hFF → `grant`=0, `opt`=0, `valid`=0, `preempt`=0; release → grant 8'h01, `opt`=0 one cycle later.
- Basic: `ptr`=0, `req`=8'b0000_0101 → `grant`=8'h01, `opt`=0; drop bit 0 → one idle cycle, then `grant`=8'h04, `opt`=2.
- Wrap: owner 6 released (`ptr`=7), `req`=8'b1000_0001 → grant 7, release, then grant 0.
- Fairness: `req`=8'hFF, each owner drops its bit for one cycle after 3 cycles of grant → `opt` sequence 0,1,…,7,0; `valid` never high on two consecutive grants without an idle cycle.
- Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD`=4): `req`=8'b0000_0011 held → grant 0 for 4 cycles, `preempt` pulse, idle, `grant`=8'h02, `opt`=1; without macro grant 0 held for 100 cycles.
- Reset mid-grant: `rst`=1 during GRANT of requester 5 → next cycle all outputs zero, then grant restarts from `ptr`=0.
